// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and helpers for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   // Elaboration-time ceil(log2(v)), used to size the hold counter.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Producer-side request/data bundle and registered arbiter results.
interface mux2_rr_arbiter_if #(parameter int W = 8);
   logic         req0;
   logic         req1;
   logic [W-1:0] I0;
   logic [W-1:0] I1;
   logic         gnt0;
   logic         gnt1;
   logic         S;
   logic [W-1:0] Y;
   logic         Y_valid;

   modport master (output req0, req1, I0, I1,
                   input  gnt0, gnt1, S, Y, Y_valid);
   modport slave  (input  req0, req1, I0, I1,
                   output gnt0, gnt1, S, Y, Y_valid);
endinterface

// File: rtl/mux2_rr_arbiter_mux2_w.sv
// W-bit 2:1 select path; s=1 picks b.
module mux2_w #(parameter int W = 8) (
   input  logic         s,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);
   assign y = s ? b : a;
endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux with a bounded hold per ownership.
module mux2_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int W        = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   mux2_rr_arbiter_if.slave bus
);
   localparam int             CW        = clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0]  HOLD_LAST = CW'(MAX_HOLD - 1);

   state_t        state;
   state_t        nxt;
   logic [CW-1:0] hold_cnt;
   logic          last;
   logic          gnt0, gnt1, sel, y_valid;
   logic [W-1:0]  y_q, mux_y;

   function automatic state_t next_state(input state_t st, input logic r0, input logic r1,
                                         input logic lst, input logic hold_done);
      state_t n;
      n = st;
      case (st)
         ST_IDLE: begin
            if (r0 && r1)  n = lst ? ST_OWN0 : ST_OWN1;
            else if (r0)   n = ST_OWN0;
            else if (r1)   n = ST_OWN1;
            else           n = ST_IDLE;
         end
         ST_OWN0: begin
            if (!r0)                  n = r1 ? ST_OWN1 : ST_IDLE;
            else if (r1 && hold_done) n = ST_OWN1;
            else                      n = ST_OWN0;
         end
         ST_OWN1: begin
            if (!r1)                  n = r0 ? ST_OWN0 : ST_IDLE;
            else if (r0 && hold_done) n = ST_OWN0;
            else                      n = ST_OWN1;
         end
         default: n = ST_IDLE;
      endcase
      return n;
   endfunction

   assign nxt = next_state(state, bus.req0, bus.req1, last, hold_cnt == HOLD_LAST);

   // Grants and select are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         hold_cnt <= '0;
         last     <= 1'b1;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         sel      <= 1'b0;
      end else begin
         state <= nxt;
         gnt0  <= (nxt == ST_OWN0);
         gnt1  <= (nxt == ST_OWN1);
         if (nxt == ST_OWN0)      sel <= 1'b0;
         else if (nxt == ST_OWN1) sel <= 1'b1;
         if (nxt != state)
            hold_cnt <= '0;
         else if (state != ST_IDLE && hold_cnt != HOLD_LAST)
            hold_cnt <= hold_cnt + 1'b1;
         if (state != ST_IDLE && nxt != state)
            last <= (state == ST_OWN1);
      end
   end

   mux2_w #(.W(W)) u_mux (
      .s (sel),
      .a (bus.I0),
      .b (bus.I1),
      .y (mux_y)
   );

   // Y only moves while someone owns the mux; IDLE keeps the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q     <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= gnt0 | gnt1;
         if (gnt0 | gnt1) y_q <= mux_y;
      end
   end

   assign bus.gnt0    = gnt0;
   assign bus.gnt1    = gnt1;
   assign bus.S       = sel;
   assign bus.Y       = y_q;
   assign bus.Y_valid = y_valid;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Checks two arbiter instances (MAX_HOLD=4 and 1) against an ownership-run model.
module tb_mux2_rr_arbiter;
   localparam int W = 8;
   localparam int MH [2] = '{4, 1};

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [W-1:0] i0 = '0, i1 = '0;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: owner -1 means nobody; run counts cycles the current owner has held;
   // prio is who wins the next tie.
   int           owner [2];
   int           run   [2];
   int           prio  [2];
   logic [W-1:0] ey    [2];
   logic         eyv   [2];
   logic         es    [2];

   mux2_rr_arbiter_if #(.W(W)) bus_a ();
   mux2_rr_arbiter_if #(.W(W)) bus_b ();

   assign bus_a.req0 = req0;
   assign bus_a.req1 = req1;
   assign bus_a.I0   = i0;
   assign bus_a.I1   = i1;
   assign bus_b.req0 = req0;
   assign bus_b.req1 = req1;
   assign bus_b.I0   = i0;
   assign bus_b.I1   = i1;

   mux2_rr_arbiter #(.W(W), .MAX_HOLD(4)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   mux2_rr_arbiter #(.W(W), .MAX_HOLD(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         owner[k] = -1; run[k] = 0; prio[k] = 0;
         ey[k] = '0; eyv[k] = 1'b0; es[k] = 1'b0;
      end
   endtask

   task automatic model_edge(input int k);
      int  o, n;
      bit  r [2];
      r[0] = req0; r[1] = req1;
      o = owner[k];
      eyv[k] = (o >= 0);
      if (o >= 0) ey[k] = (o == 1) ? i1 : i0;
      if (o < 0) begin
         if (r[0] && r[1]) n = prio[k];
         else if (r[0])    n = 0;
         else if (r[1])    n = 1;
         else              n = -1;
      end else if (!r[o]) begin
         n = r[1-o] ? 1 - o : -1;
      end else if (r[1-o] && run[k] >= MH[k]) begin
         n = 1 - o;
      end else begin
         n = o;
      end
      if (n != o) begin
         run[k] = (n >= 0) ? 1 : 0;
         if (o >= 0) prio[k] = 1 - o;
      end else if (n >= 0) begin
         run[k]++;
      end
      owner[k] = n;
      if (n >= 0) es[k] = (n == 1);
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".a.gnt0"}, 32'(bus_a.gnt0),    32'(owner[0] == 0));
      chk({tag, ".a.gnt1"}, 32'(bus_a.gnt1),    32'(owner[0] == 1));
      chk({tag, ".a.S"},    32'(bus_a.S),       32'(es[0]));
      chk({tag, ".a.Y"},    32'(bus_a.Y),       32'(ey[0]));
      chk({tag, ".a.Yv"},   32'(bus_a.Y_valid), 32'(eyv[0]));
      chk({tag, ".b.gnt0"}, 32'(bus_b.gnt0),    32'(owner[1] == 0));
      chk({tag, ".b.gnt1"}, 32'(bus_b.gnt1),    32'(owner[1] == 1));
      chk({tag, ".b.S"},    32'(bus_b.S),       32'(es[1]));
      chk({tag, ".b.Y"},    32'(bus_b.Y),       32'(ey[1]));
      chk({tag, ".b.Yv"},   32'(bus_b.Y_valid), 32'(eyv[1]));
   endtask

   // Inputs change only at negedge; model and DUT both sample them at posedge.
   task automatic step(input string tag);
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic set_in(input logic r0, input logic r1, input logic [W-1:0] d0, input logic [W-1:0] d1);
      req0 = r0; req1 = r1; i0 = d0; i1 = d1;
   endtask

   initial begin
      model_reset();
      set_in(1'b0, 1'b0, 8'hAA, 8'h00);
      repeat (2) @(negedge clk);
      check_all("in_reset");
      chk("rst.last", 32'(u_a.last), 32'd1);
      rst_n = 1'b1;

      for (int c = 0; c < 5; c++) step("idle");

      set_in(1'b1, 1'b0, 8'h11, 8'h00);
      for (int c = 0; c < 10; c++) step("req0_only");

      // Both requesting straight out of reset.
      rst_n = 1'b0;
      model_reset();
      #1 check_all("rst2");
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b1, 1'b1, 8'h11, 8'h22);
      for (int c = 0; c < 17; c++) step("both");

      for (int g = 0; g < 10 && owner[0] != 1; g++) step("seek_own1");
      chk("reach_own1", 32'(bus_a.gnt1), 32'd1);
      set_in(1'b1, 1'b0, 8'h33, 8'h44);
      step("drop_req1");
      chk("hold_clr", 32'(u_a.hold_cnt), 32'd0);
      step("drop_req1_y");

      // Reset asserted mid-ownership of requester 0.
      set_in(1'b0, 1'b0, 8'h55, 8'h66);
      repeat (2) step("to_idle");
      set_in(1'b1, 1'b0, 8'h55, 8'h66);
      for (int g = 0; g < 10 && !(owner[0] == 0 && run[0] == 3); g++) step("seek_hold2");
      chk("hold2", 32'(u_a.hold_cnt), 32'd2);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b0, 1'b1, 8'h55, 8'h66);
      repeat (3) step("post_rst_req1");

      // Random traffic biased toward contention.
      for (int c = 0; c < 300; c++) begin
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                W'($urandom), W'($urandom));
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
